uart_rx_multi: RTL and testbench

Parametrised UART receiver that generalises the team's fixed 8N1 receiver. It adds configurable frame format, 16x oversampling with majority-vote sampling, and a runtime baud divisor. Received characters and their per-character error flags go into a small FIFO, drained by the req/ready handshake. It sits between the board UART pin and the host-side command logic.

---
 rtl/uart_rx_multi.sv | 254 +++++++++++++++++++++++++
 tb/tb_uart_rx_multi.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_multi.sv
// Oversampling UART receiver with configurable frame format, majority-vote bit
// sampling, break detection and a small RX FIFO drained by a req/ready handshake.
module uart_rx_multi #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset_,
  input  logic [15:0]                   baud_div,
  input  logic                          uart_rx,
  output logic                          rx_req,
  input  logic                          rx_ready,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_parity_err,
  output logic                          rx_frame_err,
  output logic                          rx_break,
  output logic                          rx_overrun,
  input  logic                          overrun_clr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          rx_active
);

  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W   = PTR_W + 1;
  localparam int unsigned ENTRY_W = DATA_BITS + 3;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned DIV_W   = 16;
  localparam bit          ODD     = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK_WAIT
  } state_t;

  state_t state, state_nxt;

  logic sync_d, sync_dd, line_p1;
  logic sync_dd_c, fall_c;

  logic [DIV_W-1:0]     div_reload, div_cnt, reload_c;
  logic [CNT_W-1:0]     sub_cnt, bit_cnt;
  logic                 samp7, samp8;
  logic                 tick_c, sample_c, bit_val_c;

  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_bit, par_err, frm_err, stop_cnt;
  logic                 data_zero_c;
  logic                 start_c, shift_c, par_c, stop_c, wr_c, brk_c;

  logic                 wr_q;
  logic [ENTRY_W-1:0]   wr_entry;

  // Two-flop synchroniser plus one history flop for falling-edge detection
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      sync_d  <= 1'b1;
      sync_dd <= 1'b1;
      line_p1 <= 1'b1;
    end else begin
      sync_d  <= uart_rx;
      sync_dd <= sync_d;
      line_p1 <= sync_dd;
    end
  end

  assign sync_dd_c   = sync_dd;
  assign fall_c      = line_p1 & ~sync_dd_c;
  assign reload_c    = (baud_div == 16'd0) ? 16'd0 : baud_div - 16'd1;
  assign tick_c      = (state != S_IDLE) && (div_cnt == '0);
  assign sample_c    = tick_c && (sub_cnt == 4'd9);
  assign bit_val_c   = (samp7 & samp8) | (samp7 & sync_dd_c) | (samp8 & sync_dd_c);
  assign data_zero_c = (shift_reg == '0);

  // State register; rx_active follows the next state so it is registered
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state     <= S_IDLE;
      rx_active <= 1'b0;
    end else begin
      state     <= state_nxt;
      rx_active <= (state_nxt != S_IDLE);
    end
  end

  always_comb begin
    state_nxt = state;
    start_c   = 1'b0;
    shift_c   = 1'b0;
    par_c     = 1'b0;
    stop_c    = 1'b0;
    wr_c      = 1'b0;
    brk_c     = 1'b0;
    case (state)
      S_IDLE: begin
        if (fall_c) begin
          start_c   = 1'b1;
          state_nxt = S_START;
        end
      end
      S_START: begin
        if (sample_c) state_nxt = bit_val_c ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (sample_c) begin
          shift_c = 1'b1;
          if (bit_cnt == CNT_W'(DATA_BITS - 1))
            state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (sample_c) begin
          par_c     = 1'b1;
          state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (sample_c) begin
          stop_c = 1'b1;
          // An all-zero frame through the first stop bit is a break
          if (!stop_cnt && !bit_val_c && data_zero_c && !par_bit) begin
            brk_c     = 1'b1;
            wr_c      = 1'b1;
            state_nxt = S_BREAK_WAIT;
          end else if ((STOP_BITS == 2) && !stop_cnt) begin
            state_nxt = S_STOP;
          end else begin
            wr_c      = 1'b1;
            state_nxt = S_IDLE;
          end
        end
      end
      S_BREAK_WAIT: begin
        if (sync_dd_c) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Tick generator, sample capture and frame datapath
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      div_reload <= '0;
      div_cnt    <= '0;
      sub_cnt    <= '0;
      bit_cnt    <= '0;
      samp7      <= 1'b1;
      samp8      <= 1'b1;
      shift_reg  <= '0;
      par_bit    <= 1'b0;
      par_err    <= 1'b0;
      frm_err    <= 1'b0;
      stop_cnt   <= 1'b0;
      wr_q       <= 1'b0;
      wr_entry   <= '0;
    end else begin
      wr_q <= wr_c;
      if (start_c) begin
        div_reload <= reload_c;
        div_cnt    <= reload_c;
        sub_cnt    <= '0;
        bit_cnt    <= '0;
        shift_reg  <= '0;
        par_bit    <= 1'b0;
        par_err    <= 1'b0;
        frm_err    <= 1'b0;
        stop_cnt   <= 1'b0;
      end else if (state != S_IDLE) begin
        if (tick_c) begin
          div_cnt <= div_reload;
          sub_cnt <= sub_cnt + 4'd1;
          if (sub_cnt == 4'd7) samp7 <= sync_dd_c;
          if (sub_cnt == 4'd8) samp8 <= sync_dd_c;
        end else begin
          div_cnt <= div_cnt - 16'd1;
        end
      end
      if (shift_c) begin
        shift_reg <= {bit_val_c, shift_reg[DATA_BITS-1:1]};
        bit_cnt   <= bit_cnt + 4'd1;
      end
      if (par_c) begin
        par_bit <= bit_val_c;
        par_err <= (^shift_reg) ^ bit_val_c ^ ODD;
      end
      if (stop_c) begin
        stop_cnt <= 1'b1;
        if (!bit_val_c) frm_err <= 1'b1;
      end
      if (wr_c) begin
        wr_entry <= brk_c ? {1'b1, 1'b1, 1'b0, {DATA_BITS{1'b0}}}
                          : {1'b0, frm_err | ~bit_val_c, par_err, shift_reg};
      end
    end
  end

  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [LVL_W-1:0]   level_nxt;
  logic [ENTRY_W-1:0] head_nxt;
  logic               pop_c, push_c, drop_c, full_c;

  assign pop_c      = rx_req & rx_ready;
  assign full_c     = (fifo_level == LVL_W'(FIFO_DEPTH));
  assign push_c     = wr_q & (~full_c | pop_c);
  assign drop_c     = wr_q & full_c & ~pop_c;
  assign level_nxt  = fifo_level + LVL_W'(push_c) - LVL_W'(pop_c);
  assign rd_ptr_nxt = rd_ptr + PTR_W'(pop_c);

  // Next head entry: bypass the write data when the FIFO would otherwise drain
  always_comb begin
    head_nxt = '0;
    if (level_nxt != '0) begin
      if (fifo_level == LVL_W'(pop_c)) head_nxt = wr_entry;
      else                             head_nxt = mem[rd_ptr_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_level    <= '0;
      rx_req        <= 1'b0;
      rx_data       <= '0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_break      <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr     <= rd_ptr_nxt;
      fifo_level <= level_nxt;
      rx_req     <= (level_nxt != '0);
      {rx_break, rx_frame_err, rx_parity_err, rx_data} <= head_nxt;
      if (drop_c)           rx_overrun <= 1'b1;
      else if (overrun_clr) rx_overrun <= 1'b0;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (reset_ && wr_q)
      $display("uart_rx_multi %m: data=0x%h parity_err=%0b frame_err=%0b break=%0b dropped=%0b",
               wr_entry[DATA_BITS-1:0], wr_entry[DATA_BITS], wr_entry[DATA_BITS+1],
               wr_entry[DATA_BITS+2], drop_c);
  end
`endif

endmodule

// File: tb/tb_uart_rx_multi.sv
// Directed bench for uart_rx_multi: three instances (8N1, 8E1, 7N2) driven by
// per-scenario tasks with hand-computed expected FIFO entries.
module tb_uart_rx_multi;

  localparam int BIT = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_;
  logic [15:0] baud_div;
  logic [2:0]  line;

  logic       a_ready, a_clr, a_req, a_pe, a_fe, a_brk, a_ovr, a_act;
  logic [7:0] a_data;
  logic [2:0] a_lvl;
  logic       b_ready, b_clr, b_req, b_pe, b_fe, b_brk, b_ovr, b_act;
  logic [7:0] b_data;
  logic [2:0] b_lvl;
  logic       c_ready, c_clr, c_req, c_pe, c_fe, c_brk, c_ovr, c_act;
  logic [6:0] c_data;
  logic [2:0] c_lvl;

  int checks   = 0;
  int failures = 0;
  logic [11:0] cap_a [$];
  logic [11:0] got;

  uart_rx_multi u_8n1 (
    .clk(clk), .reset_(reset_), .baud_div(baud_div), .uart_rx(line[0]),
    .rx_req(a_req), .rx_ready(a_ready), .rx_data(a_data), .rx_parity_err(a_pe),
    .rx_frame_err(a_fe), .rx_break(a_brk), .rx_overrun(a_ovr), .overrun_clr(a_clr),
    .fifo_level(a_lvl), .rx_active(a_act)
  );

  uart_rx_multi #(.PARITY(2)) u_8e1 (
    .clk(clk), .reset_(reset_), .baud_div(baud_div), .uart_rx(line[1]),
    .rx_req(b_req), .rx_ready(b_ready), .rx_data(b_data), .rx_parity_err(b_pe),
    .rx_frame_err(b_fe), .rx_break(b_brk), .rx_overrun(b_ovr), .overrun_clr(b_clr),
    .fifo_level(b_lvl), .rx_active(b_act)
  );

  uart_rx_multi #(.DATA_BITS(7), .STOP_BITS(2)) u_7n2 (
    .clk(clk), .reset_(reset_), .baud_div(baud_div), .uart_rx(line[2]),
    .rx_req(c_req), .rx_ready(c_ready), .rx_data(c_data), .rx_parity_err(c_pe),
    .rx_frame_err(c_fe), .rx_break(c_brk), .rx_overrun(c_ovr), .overrun_clr(c_clr),
    .fifo_level(c_lvl), .rx_active(c_act)
  );

  // Record every entry popped from the 8N1 instance as {break, frame, parity, 0, data}
  always @(negedge clk) begin
    if (reset_ && a_req && a_ready) cap_a.push_back({a_brk, a_fe, a_pe, 1'b0, a_data});
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input int ln, input logic b);
    line[ln] = b;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send_frame(input int ln, input logic [8:0] d, input int nb, input bit has_par,
                            input logic pb, input int ns, input logic s1, input logic s2);
    drive_bit(ln, 1'b0);
    for (int i = 0; i < nb; i++) drive_bit(ln, d[i]);
    if (has_par) drive_bit(ln, pb);
    drive_bit(ln, s1);
    if (ns == 2) drive_bit(ln, s2);
    line[ln] = 1'b1;
    idle(16);
  endtask

  task automatic test_reset;
    checks++; if (a_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", a_req); end
    checks++; if (a_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", a_data); end
    checks++; if (a_lvl !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", a_lvl); end
    checks++; if (a_ovr !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", a_ovr); end
    checks++; if (a_act !== 1'b0) begin failures++; $display("FAIL reset_active got=%b exp=0", a_act); end
    checks++; if ({a_pe, a_fe, a_brk} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {a_pe, a_fe, a_brk}); end
  endtask

  task automatic test_basic;
    cap_a.delete();
    a_ready = 1'b1;
    send_frame(0, 9'h055, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    send_frame(0, 9'h0A3, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    idle(8);
    a_ready = 1'b0;
    checks++; if (cap_a.size() != 2) begin failures++; $display("FAIL basic_count got=%0d exp=2", cap_a.size()); end
    got = (cap_a.size() > 0) ? cap_a[0] : 12'hFFF;
    checks++; if (got !== 12'h055) begin failures++; $display("FAIL basic_first got=%h exp=055", got); end
    got = (cap_a.size() > 1) ? cap_a[1] : 12'hFFF;
    checks++; if (got !== 12'h0A3) begin failures++; $display("FAIL basic_second got=%h exp=0a3", got); end
    checks++; if (a_lvl !== 3'd0) begin failures++; $display("FAIL basic_level got=%0d exp=0", a_lvl); end
  endtask

  task automatic test_parity;
    b_ready = 1'b0;
    // 0xA3 has four ones: even parity bit should be 0, send 1
    send_frame(1, 9'h0A3, 8, 1'b1, 1'b1, 1, 1'b1, 1'b1);
    idle(4);
    checks++; if (b_req !== 1'b1) begin failures++; $display("FAIL parity_req got=%b exp=1", b_req); end
    checks++; if (b_data !== 8'hA3) begin failures++; $display("FAIL parity_data got=%h exp=a3", b_data); end
    checks++; if (b_pe !== 1'b1) begin failures++; $display("FAIL parity_err got=%b exp=1", b_pe); end
    checks++; if (b_fe !== 1'b0) begin failures++; $display("FAIL parity_frame got=%b exp=0", b_fe); end
    b_ready = 1'b1; idle(1); b_ready = 1'b0; idle(2);
    // 0x07 has three ones: even parity bit 1 is correct
    send_frame(1, 9'h007, 8, 1'b1, 1'b1, 1, 1'b1, 1'b1);
    idle(4);
    checks++; if (b_lvl !== 3'd1) begin failures++; $display("FAIL parity_ok_level got=%0d exp=1", b_lvl); end
    checks++; if ({b_data, b_pe} !== {8'h07, 1'b0}) begin failures++; $display("FAIL parity_ok got=%h/%b exp=07/0", b_data, b_pe); end
    b_ready = 1'b1; idle(1); b_ready = 1'b0; idle(2);
  endtask

  task automatic test_false_start;
    line[0] = 1'b0;
    idle(5);
    checks++; if (a_act !== 1'b1) begin failures++; $display("FAIL false_start_active got=%b exp=1", a_act); end
    idle(7);
    line[0] = 1'b1;
    idle(60);
    checks++; if (a_act !== 1'b0) begin failures++; $display("FAIL false_start_idle got=%b exp=0", a_act); end
    checks++; if (a_req !== 1'b0) begin failures++; $display("FAIL false_start_req got=%b exp=0", a_req); end
    checks++; if (a_lvl !== 3'd0) begin failures++; $display("FAIL false_start_level got=%0d exp=0", a_lvl); end
  endtask

  task automatic test_overrun;
    cap_a.delete();
    a_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send_frame(0, 9'(i), 8, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    idle(4);
    checks++; if (a_lvl !== 3'd4) begin failures++; $display("FAIL ovr_level got=%0d exp=4", a_lvl); end
    checks++; if (a_ovr !== 1'b1) begin failures++; $display("FAIL ovr_flag got=%b exp=1", a_ovr); end
    checks++; if (a_data !== 8'h01) begin failures++; $display("FAIL ovr_head got=%h exp=01", a_data); end
    a_ready = 1'b1; idle(8); a_ready = 1'b0; idle(2);
    checks++; if (cap_a.size() != 4) begin failures++; $display("FAIL ovr_drain_count got=%0d exp=4", cap_a.size()); end
    for (int i = 0; i < 4; i++) begin
      got = (cap_a.size() > i) ? cap_a[i] : 12'hFFF;
      checks++; if (got !== 12'(i + 1)) begin failures++; $display("FAIL ovr_drain_%0d got=%h exp=%h", i, got, 12'(i + 1)); end
    end
    checks++; if (a_lvl !== 3'd0) begin failures++; $display("FAIL ovr_drained_level got=%0d exp=0", a_lvl); end
    checks++; if (a_ovr !== 1'b1) begin failures++; $display("FAIL ovr_sticky got=%b exp=1", a_ovr); end
    a_clr = 1'b1; idle(1); a_clr = 1'b0; idle(1);
    checks++; if (a_ovr !== 1'b0) begin failures++; $display("FAIL ovr_clear got=%b exp=0", a_ovr); end
  endtask

  task automatic test_break;
    cap_a.delete();
    a_ready = 1'b0;
    line[0] = 1'b0;
    idle(20 * BIT);
    checks++; if (a_lvl !== 3'd1) begin failures++; $display("FAIL break_level got=%0d exp=1", a_lvl); end
    checks++; if ({a_brk, a_fe, a_pe, a_data} !== {3'b110, 8'h00}) begin failures++; $display("FAIL break_entry got=%b%b%b/%h exp=110/00", a_brk, a_fe, a_pe, a_data); end
    checks++; if (a_act !== 1'b1) begin failures++; $display("FAIL break_wait_active got=%b exp=1", a_act); end
    line[0] = 1'b1;
    idle(BIT);
    checks++; if (a_act !== 1'b0) begin failures++; $display("FAIL break_release got=%b exp=0", a_act); end
    send_frame(0, 9'h07E, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    idle(4);
    checks++; if (a_lvl !== 3'd2) begin failures++; $display("FAIL break_after_level got=%0d exp=2", a_lvl); end
    a_ready = 1'b1; idle(4); a_ready = 1'b0;
    got = (cap_a.size() > 0) ? cap_a[0] : 12'hFFF;
    checks++; if (got !== 12'hC00) begin failures++; $display("FAIL break_pop got=%h exp=c00", got); end
    got = (cap_a.size() > 1) ? cap_a[1] : 12'hFFF;
    checks++; if (got !== 12'h07E) begin failures++; $display("FAIL break_next got=%h exp=07e", got); end
  endtask

  task automatic test_stop2_reset;
    c_ready = 1'b0;
    send_frame(2, 9'h041, 7, 1'b0, 1'b0, 2, 1'b1, 1'b0);
    idle(4);
    checks++; if (c_data !== 7'h41) begin failures++; $display("FAIL stop2_data got=%h exp=41", c_data); end
    checks++; if ({c_fe, c_pe, c_brk} !== 3'b100) begin failures++; $display("FAIL stop2_flags got=%b exp=100", {c_fe, c_pe, c_brk}); end
    drive_bit(2, 1'b0);
    drive_bit(2, 1'b1);
    drive_bit(2, 1'b0);
    checks++; if (c_act !== 1'b1) begin failures++; $display("FAIL midframe_active got=%b exp=1", c_act); end
    reset_  = 1'b0;
    line[2] = 1'b1;
    idle(2);
    checks++; if (c_lvl !== 3'd0) begin failures++; $display("FAIL midreset_level got=%0d exp=0", c_lvl); end
    checks++; if (c_req !== 1'b0) begin failures++; $display("FAIL midreset_req got=%b exp=0", c_req); end
    checks++; if (c_act !== 1'b0) begin failures++; $display("FAIL midreset_active got=%b exp=0", c_act); end
    reset_ = 1'b1;
    idle(20);
    send_frame(2, 9'h02A, 7, 1'b0, 1'b0, 2, 1'b1, 1'b1);
    idle(4);
    checks++; if (c_lvl !== 3'd1) begin failures++; $display("FAIL post_reset_level got=%0d exp=1", c_lvl); end
    checks++; if ({c_fe, c_pe, c_brk, c_data} !== {3'b000, 7'h2A}) begin failures++; $display("FAIL post_reset_entry got=%b%b%b/%h exp=000/2a", c_fe, c_pe, c_brk, c_data); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset_   = 1'b0;
    baud_div = 16'd4;
    line     = 3'b111;
    a_ready = 1'b0; a_clr = 1'b0;
    b_ready = 1'b0; b_clr = 1'b0;
    c_ready = 1'b0; c_clr = 1'b0;
    idle(4);
    test_reset();
    reset_ = 1'b1;
    idle(8);
    test_basic();
    test_parity();
    test_false_start();
    test_overrun();
    test_break();
    test_stop2_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
